// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit CPU datapath: widths, ALU opcodes, flag bit
// positions and reset values.
package cpu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] ALU_ADD   = 4'h0;
  localparam logic [OP_W-1:0] ALU_SUB   = 4'h1;
  localparam logic [OP_W-1:0] ALU_AND   = 4'h2;
  localparam logic [OP_W-1:0] ALU_OR    = 4'h3;
  localparam logic [OP_W-1:0] ALU_XOR   = 4'h4;
  localparam logic [OP_W-1:0] ALU_NOT   = 4'h5;
  localparam logic [OP_W-1:0] ALU_SHL   = 4'h6;
  localparam logic [OP_W-1:0] ALU_SHR   = 4'h7;
  localparam logic [OP_W-1:0] ALU_INC   = 4'h8;
  localparam logic [OP_W-1:0] ALU_DEC   = 4'h9;
  localparam logic [OP_W-1:0] ALU_CMP   = 4'hA;
  localparam logic [OP_W-1:0] ALU_PASSB = 4'hB;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  localparam logic [DATA_W-1:0] REG_RESET        = 8'h00;
  localparam logic [DATA_W-1:0] SP_RESET_DEFAULT = 8'hFF;
  localparam logic [ADDR_W-1:0] PC_RESET         = 16'h0000;

  // Assemble a flags byte; upper nibble always reads as zero
  function automatic logic [DATA_W-1:0] pack_flags(input logic c, input logic z,
                                                   input logic n, input logic v);
    logic [DATA_W-1:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/cpu_alu_core.sv
// Registered 8-bit ALU: A = accumulator, B = memory data; result/flags latch on
// start and done pulses for one cycle. Signed overflow flag when ALU_OVF_FLAG_EN.
module cpu_alu_core
  import cpu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic [DATA_W-1:0] o_flags,
  output logic              o_done
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W:0]   w_inc;
  logic [DATA_W:0]   w_dec;
  logic [DATA_W-1:0] w_res;
  logic [DATA_W-1:0] w_zn_src;
  logic              w_c;
  logic              w_v;

  // Carry/borrow land in bit 8 of each 9-bit intermediate
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_inc  = {1'b0, i_a} + 9'd1;
  assign w_dec  = {1'b0, i_a} - 9'd1;

  always_comb begin
    w_res    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (i_op)
      ALU_ADD:   begin w_res = w_sum[DATA_W-1:0];  w_c = w_sum[DATA_W];  end
      ALU_SUB:   begin w_res = w_diff[DATA_W-1:0]; w_c = w_diff[DATA_W]; end
      ALU_AND:   w_res = i_a & i_b;
      ALU_OR:    w_res = i_a | i_b;
      ALU_XOR:   w_res = i_a ^ i_b;
      ALU_NOT:   w_res = ~i_a;
      ALU_SHL:   begin w_res = {i_a[DATA_W-2:0], 1'b0}; w_c = i_a[DATA_W-1]; end
      ALU_SHR:   begin w_res = {1'b0, i_a[DATA_W-1:1]}; w_c = i_a[0]; end
      ALU_INC:   begin w_res = w_inc[DATA_W-1:0];  w_c = w_inc[DATA_W];  end
      ALU_DEC:   begin w_res = w_dec[DATA_W-1:0];  w_c = w_dec[DATA_W];  end
      ALU_CMP:   begin w_res = i_a;                w_c = w_diff[DATA_W]; end
      ALU_PASSB: w_res = i_b;
      default:   w_res = '0;
    endcase
`ifdef ALU_OVF_FLAG_EN
    case (i_op)
      ALU_ADD: w_v = (i_a[7] == i_b[7]) && (w_sum[7] != i_a[7]);
      ALU_SUB,
      ALU_CMP: w_v = (i_a[7] != i_b[7]) && (w_diff[7] != i_a[7]);
      ALU_INC: w_v = ~i_a[7] & w_inc[7];
      ALU_DEC: w_v = i_a[7] & ~w_dec[7];
      default: w_v = 1'b0;
    endcase
`else
    w_v = 1'b0;
`endif
    // CMP reports Z/N from the difference while returning A unchanged
    w_zn_src = (i_op == ALU_CMP) ? w_diff[DATA_W-1:0] : w_res;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_result <= '0;
      o_flags  <= '0;
      o_done   <= 1'b0;
    end else begin
      o_done <= i_start;
      if (i_start) begin
        o_result <= w_res;
        o_flags  <= pack_flags(w_c, (w_zn_src == '0), w_zn_src[DATA_W-1], w_v);
      end
    end
  end

endmodule

// File: rtl/cpu_datapath.sv
// 8-bit CPU datapath: architectural register file, 16-bit PC and registered ALU.
// Optional signed-overflow flag via ALU_OVF_FLAG_EN (handled in cpu_alu_core).
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter logic [7:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_acc_write,
  input  logic              i_acc_from_alu,
  input  logic              i_x_write,
  input  logic              i_y_write,
  input  logic              i_sp_write,
  input  logic              i_ir_write,
  input  logic              i_flags_write,
  input  logic              i_pc_write,
  input  logic              i_pc_load,
  input  logic              i_pc_inc,
  input  logic [ADDR_W-1:0] i_pc_direct,
  input  logic              i_alu_start,
  input  logic [OP_W-1:0]   i_alu_operation,
  output logic [DATA_W-1:0] o_acc_out,
  output logic [DATA_W-1:0] o_x_out,
  output logic [DATA_W-1:0] o_y_out,
  output logic [DATA_W-1:0] o_sp_out,
  output logic [DATA_W-1:0] o_ir_out,
  output logic [DATA_W-1:0] o_flags_out,
  output logic [ADDR_W-1:0] o_pc_out,
  output logic [ADDR_W-1:0] o_addr_bus,
  output logic [DATA_W-1:0] o_alu_result,
  output logic [DATA_W-1:0] o_alu_flags,
  output logic              o_alu_done
);

  logic [DATA_W-1:0] r_acc, r_x, r_y, r_sp, r_ir, r_flags;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] w_alu_result, w_alu_flags;
  logic              w_alu_done;

  cpu_alu_core u_alu (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (i_alu_start),
    .i_op     (i_alu_operation),
    .i_a      (r_acc),
    .i_b      (i_data_in),
    .o_result (w_alu_result),
    .o_flags  (w_alu_flags),
    .o_done   (w_alu_done)
  );

  // Register file; flags_write outranks the ALU flag update from acc_write
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc   <= REG_RESET;
      r_x     <= REG_RESET;
      r_y     <= REG_RESET;
      r_sp    <= SP_RESET;
      r_ir    <= REG_RESET;
      r_flags <= REG_RESET;
    end else begin
      if (i_acc_write) r_acc <= i_acc_from_alu ? w_alu_result : i_data_in;
      if (i_x_write)   r_x   <= i_data_in;
      if (i_y_write)   r_y   <= i_data_in;
      if (i_sp_write)  r_sp  <= i_data_in;
      if (i_ir_write)  r_ir  <= i_data_in;
      if (i_flags_write)                     r_flags <= i_data_in;
      else if (i_acc_write && i_acc_from_alu) r_flags <= w_alu_flags;
    end
  end

  // PC priority: absolute load, then low-byte write, then increment (wraps)
  always_ff @(posedge i_clk) begin
    if (i_reset)         r_pc <= PC_RESET;
    else if (i_pc_load)  r_pc <= i_pc_direct;
    else if (i_pc_write) r_pc <= {r_pc[ADDR_W-1:DATA_W], i_data_in};
    else if (i_pc_inc)   r_pc <= r_pc + 16'd1;
  end

  assign o_acc_out    = r_acc;
  assign o_x_out      = r_x;
  assign o_y_out      = r_y;
  assign o_sp_out     = r_sp;
  assign o_ir_out     = r_ir;
  assign o_flags_out  = r_flags;
  assign o_pc_out     = r_pc;
  assign o_addr_bus   = r_pc;
  assign o_alu_result = w_alu_result;
  assign o_alu_flags  = w_alu_flags;
  assign o_alu_done   = w_alu_done;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios followed by random
// strobe traffic compared against an arithmetic reference model.
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        acc_write, acc_from_alu, x_write, y_write, sp_write, ir_write;
  logic        flags_write, pc_write, pc_load, pc_inc, alu_start;
  logic [15:0] pc_direct;
  logic [3:0]  alu_operation;
  logic [7:0]  acc_out, x_out, y_out, sp_out, ir_out, flags_out, alu_result, alu_flags;
  logic [15:0] pc_out, addr_bus;
  logic        alu_done;

  int n_checks = 0;
  int n_fail   = 0;

  int m_acc, m_x, m_y, m_sp, m_ir, m_flags, m_pc, m_res, m_aflags, m_done;

  always #5 clk = ~clk;

  cpu_datapath dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_data_in       (data_in),
    .i_acc_write     (acc_write),
    .i_acc_from_alu  (acc_from_alu),
    .i_x_write       (x_write),
    .i_y_write       (y_write),
    .i_sp_write      (sp_write),
    .i_ir_write      (ir_write),
    .i_flags_write   (flags_write),
    .i_pc_write      (pc_write),
    .i_pc_load       (pc_load),
    .i_pc_inc        (pc_inc),
    .i_pc_direct     (pc_direct),
    .i_alu_start     (alu_start),
    .i_alu_operation (alu_operation),
    .o_acc_out       (acc_out),
    .o_x_out         (x_out),
    .o_y_out         (y_out),
    .o_sp_out        (sp_out),
    .o_ir_out        (ir_out),
    .o_flags_out     (flags_out),
    .o_pc_out        (pc_out),
    .o_addr_bus      (addr_bus),
    .o_alu_result    (alu_result),
    .o_alu_flags     (alu_flags),
    .o_alu_done      (alu_done)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  function automatic int to_signed8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference ALU from the opcode table using plain integer arithmetic
  function automatic void alu_ref(input int op, input int a, input int b,
                                  output int res, output int flg);
    int full, c, zn, sres;
    c = 0; sres = 0; full = 0;
    case (op)
      0:  begin full = a + b;     res = full % 256;        c = (full > 255) ? 1 : 0; sres = to_signed8(a) + to_signed8(b); end
      1:  begin full = a - b;     res = (full + 256) % 256; c = (a < b) ? 1 : 0;     sres = to_signed8(a) - to_signed8(b); end
      2:  res = a & b;
      3:  res = a | b;
      4:  res = a ^ b;
      5:  res = 255 - a;
      6:  begin res = (a * 2) % 256; c = a / 128; end
      7:  begin res = a / 2;         c = a % 2;   end
      8:  begin res = (a + 1) % 256;   c = (a == 255) ? 1 : 0; sres = to_signed8(a) + 1; end
      9:  begin res = (a + 255) % 256; c = (a == 0) ? 1 : 0;   sres = to_signed8(a) - 1; end
      10: begin res = a; c = (a < b) ? 1 : 0; sres = to_signed8(a) - to_signed8(b); end
      11: res = b;
      default: res = 0;
    endcase
    zn  = (op == 10) ? (a - b + 256) % 256 : res;
    flg = c + ((zn == 0) ? 2 : 0) + ((zn >= 128) ? 4 : 0);
`ifdef ALU_OVF_FLAG_EN
    if (sres > 127 || sres < -128) flg += 8;
`endif
  endfunction

  task automatic clear_strobes();
    reset = 0; acc_write = 0; acc_from_alu = 0; x_write = 0; y_write = 0;
    sp_write = 0; ir_write = 0; flags_write = 0; pc_write = 0; pc_load = 0;
    pc_inc = 0; alu_start = 0;
  endtask

  // Advance one clock, update the model from the sampled inputs, compare all outputs
  task automatic tick();
    int nres, nflg;
    @(posedge clk);
    if (reset) begin
      m_acc = 0; m_x = 0; m_y = 0; m_ir = 0; m_flags = 0; m_sp = 255; m_pc = 0;
      m_res = 0; m_aflags = 0; m_done = 0;
    end else begin
      if (flags_write) m_flags = data_in;
      else if (acc_write && acc_from_alu) m_flags = m_aflags;
      if (acc_write) m_acc = acc_from_alu ? m_res : int'(data_in);
      if (x_write)  m_x  = data_in;
      if (y_write)  m_y  = data_in;
      if (sp_write) m_sp = data_in;
      if (ir_write) m_ir = data_in;
      if (pc_load)       m_pc = pc_direct;
      else if (pc_write) m_pc = (m_pc / 256) * 256 + int'(data_in);
      else if (pc_inc)   m_pc = (m_pc + 1) % 65536;
      if (alu_start) begin
        alu_ref(int'(alu_operation), int'(acc_out), int'(data_in), nres, nflg);
        m_res = nres; m_aflags = nflg;
      end
      m_done = alu_start ? 1 : 0;
    end
    #1;
    check_eq("acc",   16'(acc_out),    16'(m_acc));
    check_eq("x",     16'(x_out),      16'(m_x));
    check_eq("y",     16'(y_out),      16'(m_y));
    check_eq("sp",    16'(sp_out),     16'(m_sp));
    check_eq("ir",    16'(ir_out),     16'(m_ir));
    check_eq("flags", 16'(flags_out),  16'(m_flags));
    check_eq("pc",    pc_out,          16'(m_pc));
    check_eq("addr",  addr_bus,        16'(m_pc));
    check_eq("res",   16'(alu_result), 16'(m_res));
    check_eq("aflg",  16'(alu_flags),  16'(m_aflags));
    check_eq("done",  16'(alu_done),   16'(m_done));
  endtask

  initial begin
    clear_strobes();
    data_in = 8'h00; pc_direct = 16'h0000; alu_operation = 4'h0;
    m_acc = 0; m_x = 0; m_y = 0; m_sp = 255; m_ir = 0; m_flags = 0; m_pc = 0;
    m_res = 0; m_aflags = 0; m_done = 0;

    // Reset state
    reset = 1; tick(); reset = 0;
    check_eq("rst_acc", 16'(acc_out), 16'h0000);
    check_eq("rst_sp", 16'(sp_out), 16'h00FF);
    check_eq("rst_pc", pc_out, 16'h0000);
    check_eq("rst_done", 16'(alu_done), 16'h0000);

    // Load ACC from memory, bump PC twice
    data_in = 8'h05; acc_write = 1; tick(); clear_strobes();
    check_eq("ld_acc", 16'(acc_out), 16'h0005);
    pc_inc = 1; tick(); tick(); clear_strobes();
    check_eq("pc_inc2", pc_out, 16'h0002);
    check_eq("addr_inc2", addr_bus, 16'h0002);

    // ADD 5+3, then write result back
    data_in = 8'h03; alu_operation = 4'h0; alu_start = 1; tick(); clear_strobes();
    check_eq("add_res", 16'(alu_result), 16'h0008);
    check_eq("add_flags", 16'(alu_flags), 16'h0000);
    check_eq("add_done", 16'(alu_done), 16'h0001);
    acc_write = 1; acc_from_alu = 1; tick(); clear_strobes();
    check_eq("wb_acc", 16'(acc_out), 16'h0008);
    check_eq("done_clr", 16'(alu_done), 16'h0000);

    // 0xFF + 0x01: carry and zero
    data_in = 8'hFF; acc_write = 1; tick(); clear_strobes();
    data_in = 8'h01; alu_operation = 4'h0; alu_start = 1; tick(); clear_strobes();
    check_eq("addc_res", 16'(alu_result), 16'h0000);
    check_eq("addc_flags", 16'(alu_flags), 16'h0003);

    // 0x80 - 0x01: signed overflow
    data_in = 8'h80; acc_write = 1; tick(); clear_strobes();
    data_in = 8'h01; alu_operation = 4'h1; alu_start = 1; tick(); clear_strobes();
    check_eq("sub_res", 16'(alu_result), 16'h007F);
`ifdef ALU_OVF_FLAG_EN
    check_eq("sub_flags", 16'(alu_flags), 16'h0008);
`else
    check_eq("sub_flags", 16'(alu_flags), 16'h0000);
`endif

    // flags_write beats the ALU flag update
    data_in = 8'hA5; flags_write = 1; acc_write = 1; acc_from_alu = 1; tick(); clear_strobes();
    check_eq("flg_prio", 16'(flags_out), 16'h00A5);

    // PC wrap and strobe priority
    pc_direct = 16'hFFFF; pc_load = 1; tick(); clear_strobes();
    pc_inc = 1; tick(); clear_strobes();
    check_eq("pc_wrap", pc_out, 16'h0000);
    pc_direct = 16'h1234; data_in = 8'h77; pc_load = 1; pc_write = 1; pc_inc = 1; tick(); clear_strobes();
    check_eq("pc_prio", pc_out, 16'h1234);
    data_in = 8'h9C; pc_write = 1; pc_inc = 1; tick(); clear_strobes();
    check_eq("pc_wr_lo", pc_out, 16'h129C);

    // Reset while an ALU completion is pending
    data_in = 8'h10; alu_operation = 4'h3; alu_start = 1; tick(); clear_strobes();
    reset = 1; tick(); clear_strobes();
    check_eq("rst_mid_done", 16'(alu_done), 16'h0000);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 49) == 0);
      data_in       = 8'($urandom);
      acc_write     = ($urandom_range(0, 2) == 0);
      acc_from_alu  = $urandom_range(0, 1) == 1;
      x_write       = ($urandom_range(0, 3) == 0);
      y_write       = ($urandom_range(0, 3) == 0);
      sp_write      = ($urandom_range(0, 5) == 0);
      ir_write      = ($urandom_range(0, 3) == 0);
      flags_write   = ($urandom_range(0, 7) == 0);
      pc_load       = ($urandom_range(0, 9) == 0);
      pc_write      = ($urandom_range(0, 7) == 0);
      pc_inc        = ($urandom_range(0, 1) == 1);
      pc_direct     = (i % 37 == 0) ? 16'hFFFF : 16'($urandom);
      alu_start     = ($urandom_range(0, 1) == 1);
      alu_operation = 4'($urandom_range(0, 15));
      tick();
    end
    clear_strobes();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
8-bit CPU datapath combining the architectural register file (ACC, X, Y, SP, IR, FLAGS, 16-bit PC) and a registered 8-bit ALU.
- Driven by the control unit through discrete write, increment and load strobes.
- PC drives the external memory address bus.
- Memory read data enters on data_in; it is also the ALU B operand.
- ALU A operand is always ACC.

Parameters:
SP_RESET, 8'hFF, stack pointer value after reset.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
data_in  in  8  data bus from memory; register load source and ALU B operand
acc_write  in  1  load ACC (source per acc_from_alu)
acc_from_alu  in  1  1: ACC <= alu_result and FLAGS <= alu_flags; 0: ACC <= data_in
x_write, y_write, sp_write, ir_write  in  1 each  load register from data_in
flags_write  in  1  FLAGS <= data_in
pc_write  in  1  PC[7:0] <= data_in, PC[15:8] unchanged
pc_load  in  1  PC <= pc_direct
pc_inc  in  1  PC <= PC + 1
pc_direct  in  16  jump target
alu_start  in  1  launch ALU operation
alu_operation  in  4  opcode
acc_out, x_out, y_out, sp_out, ir_out, flags_out  out  8 each  register contents
pc_out  out  16  program counter
addr_bus  out  16  equals pc_out, combinational
alu_result  out  8  registered ALU result
alu_flags  out  8  registered ALU flags
alu_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, active-high): ACC, X, Y, IR, FLAGS = 0x00; PC = 0x0000; SP = SP_RESET; alu_result = 0, alu_flags = 0, alu_done = 0.
- Reset has priority over every strobe.
- Registers are written on the rising edge; the new value is visible after the edge.
- Independent strobes may fire in the same cycle.
- PC priority: pc_load > pc_write > pc_inc. pc_inc wraps 0xFFFF -> 0x0000.
- FLAGS update: flags_write (data_in) has priority over the FLAGS update from acc_write with acc_from_alu.
- Flag bit layout: [0] C, [1] Z, [2] N, [3] V (see feature), [7:4] = 0.
- ALU operands: A = acc_out, B = data_in.
- ALU timing: on a clk edge with alu_start = 1, result and flags register; alu_done = 1 during the following cycle only. Without alu_start, outputs hold and alu_done = 0.
- Opcodes:
  - 0 ADD: A+B, C = carry out
  - 1 SUB: A-B, C = borrow (A<B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL: C = A[7]
  - 7 SHR logical: C = A[0]
  - 8 INC A: C = carry
  - 9 DEC A: C = borrow
  - A CMP: flags as SUB, result = A
  - B PASSB: result = B
  - C-F: result 0x00, flags Z=1, others 0
- Unless stated, C = 0.
- Z = (result == 0); N = result[7]; CMP uses the subtraction result for Z and N.
- Reset mid-operation: a pending alu_done is cleared.

Optional Feature:
ALU_OVF_FLAG_EN: when defined, flags[3] = signed overflow:
- ADD/INC: operands of the same sign, result sign differs.
- SUB/DEC/CMP: operands of differing sign, result sign differs from A.
When not defined, flags[3] is constant 0.

Decomposition:
- Shared package cpu_pkg: opcode localparams (ALU_ADD..ALU_PASSB), flag bit indices (FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3), reset constants.
- One sub-module, cpu_alu_core: the registered ALU with the start/done handshake.
- The register file lives in the top level.

Test Plan:
- Assert reset one cycle -> ACC=0x00, X=0x00, Y=0x00, FLAGS=0x00, PC=0x0000, SP=0xFF, alu_done=0.
- data_in=0x05, acc_write=1, acc_from_alu=0 -> ACC=0x05; pulse pc_inc twice -> PC=0x0002, addr_bus=0x0002.
- ACC=0x05, data_in=0x03, ADD with alu_start -> next cycle alu_result=0x08, alu_done=1 one cycle, C=0, Z=0, N=0; acc_write with acc_from_alu -> ACC=0x08, FLAGS=0x00.
- ACC=0xFF, data_in=0x01, ADD -> result 0x00, flags C=1, Z=1 (0x03).
- ACC=0x80, data_in=0x01, SUB -> 0x7F; with ALU_OVF_FLAG_EN V=1 (flags 0x08), without it 0x00.
- PC=0xFFFF with pc_inc -> 0x0000; pc_load, pc_write and pc_inc together with pc_direct=0x1234 -> PC=0x1234.
